handshake_sender: RTL



---
 rtl/handshake_sender.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/handshake_sender.sv
// handshake_sender: transmitting end of a four-phase req/ack link between clock domains.
// An accepted start snapshots the n-bit payload. The sender then sends a header word
// (nibble 4'hA) followed by ceil(n/4) nibble words, LSB nibble first. Each word uses
// one full req/ack four-phase cycle.
// Word format: [3:0] nibble, [4] abort/last flag (always 0 here), [5] odd parity.
// Optional feature macro: HANDSHAKE_SENDER_ACK_TIMEOUT_EN. When it is defined, the
// sender abandons a transfer if the receiver stalls for TIMEOUT_CYCLES cycles in one
// handshake phase.
module handshake_sender #(
  parameter int n              = 1500,
  parameter int SYNC_STAGES    = 2,     // legal range 2..4
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk_sender,
  input  logic         rst,
  input  logic         wire_start,
  input  logic [n-1:0] wire_data_in,
  input  logic         wire_ack,
  output logic         reg_req,
  output logic [5:0]   reg_data_deliver,
  output logic         reg_busy,
  output logic         reg_done,
  output logic         reg_error
);

  localparam int NUM_WORDS = (n + 3) / 4;
  localparam int PAD_W     = NUM_WORDS * 4;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS);
  localparam logic [5:0] HEADER_WORD = 6'h2A;

  typedef enum logic [2:0] {IDLE, LOAD, REQ, RELEASE, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       word_cnt;      // 0 = header, k+1 = data word k
  logic [n-1:0]           shadow;
  logic [PAD_W-1:0]       shadow_pad;
  logic [3:0]             next_nibble;
  logic [SYNC_STAGES-1:0] ack_sync_reg;
  logic                   ack_sync;
  logic                   timeout_hit;

  // Odd parity over the whole word: bit5 makes the XOR of all six bits equal 1.
  function automatic logic [5:0] encode_word(input logic [3:0] nib);
    return {~^{1'b0, nib}, 1'b0, nib};
  endfunction

  // Zero-pad the payload so the top nibble is well defined when n%4 != 0.
  assign shadow_pad = PAD_W'(shadow);
  assign ack_sync   = ack_sync_reg[SYNC_STAGES-1];

  // Next data nibble: data word k is sent after the word at counter value k.
  always_comb begin
    next_nibble = 4'h0;
    if (int'(word_cnt) < NUM_WORDS) begin
      next_nibble = shadow_pad[4*int'(word_cnt) +: 4];
    end
  end

  // Bring the asynchronous acknowledge into the sender clock domain.
  always_ff @(posedge clk_sender or posedge rst) begin
    if (rst) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], wire_ack};
    end
  end

`ifdef HANDSHAKE_SENDER_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             stay_wait;

  // The FSM stays in a wait state while the receiver has not yet answered the current phase.
  assign stay_wait   = ((state == REQ) && !ack_sync) || ((state == RELEASE) && ack_sync);
  assign timeout_hit = stay_wait && (tmo_cnt == TMO_LIMIT);

  // Count cycles spent in one wait state. The count restarts on every state change.
  always_ff @(posedge clk_sender or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (stay_wait && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic tmo_unused;
  assign tmo_unused  = |TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Main FSM: the word sequencing and all outputs are registered here.
  always_ff @(posedge clk_sender or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      word_cnt         <= '0;
      shadow           <= '0;
      reg_req          <= 1'b0;
      reg_data_deliver <= 6'h00;
      reg_busy         <= 1'b0;
      reg_done         <= 1'b0;
      reg_error        <= 1'b0;
    end else begin
      reg_done  <= 1'b0;
      reg_error <= 1'b0;
      case (state)
        IDLE: begin
          if (wire_start) begin
            shadow           <= wire_data_in;
            word_cnt         <= '0;
            reg_busy         <= 1'b1;
            reg_data_deliver <= HEADER_WORD;
            state            <= LOAD;
          end
        end
        LOAD: begin
          // The data has been stable for one cycle, so raise the request now.
          reg_req <= 1'b1;
          state   <= REQ;
        end
        REQ: begin
          if (timeout_hit) begin
            reg_req   <= 1'b0;
            reg_error <= 1'b1;
            reg_busy  <= 1'b0;
            state     <= IDLE;
          end else if (ack_sync) begin
            reg_req <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (timeout_hit) begin
            reg_error <= 1'b1;
            reg_busy  <= 1'b0;
            state     <= IDLE;
          end else if (!ack_sync) begin
            if (word_cnt == LAST_WORD) begin
              reg_done <= 1'b1;
              state    <= DONE;
            end else begin
              // The bus changes only once the acknowledge has fully returned low.
              word_cnt         <= word_cnt + 1'b1;
              reg_data_deliver <= encode_word(next_nibble);
              state            <= LOAD;
            end
          end
        end
        DONE: begin
          reg_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          reg_req  <= 1'b0;
          reg_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
